// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// State encoding, latched request bundle, misalign helper.
package dmem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              is_byte;
  } mem_req_t;

  function automatic logic misaligned(input mem_req_t r);
    return !r.is_byte && (r.addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker.
// The requester that did not win last time wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant, zero when nobody asks
  always_comb begin
    grant[0] = req[0] & (~req[1] | last_grant);
    grant[1] = req[1] & (~req[0] | ~last_grant);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of the data memory.
// Macro DMEM_ARB_MISALIGN_TRAP_EN enables the misaligned-word trap.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DATA_WIDTH    = DATA_W,
  parameter int NREQ          = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0][ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]     req_wdata,
  input  logic [NREQ-1:0]                     req_we,
  input  logic [NREQ-1:0]                     req_byte,
  output logic [NREQ-1:0]                     rsp_valid,
  input  logic [NREQ-1:0]                     rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic [ADDRESS_WIDTH-1:0]            mem_a,
  output logic [DATA_WIDTH-1:0]               mem_wd,
  output logic                                mem_we,
  output logic                                mem_adtp,
  input  logic [DATA_WIDTH-1:0]               mem_rd
);

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic                   last_grant;
  logic                   gsel;
  logic [1:0]             grant;
  logic                   trap;
  logic                   accept;
  mem_req_t               lat;
  logic [DATA_WIDTH-1:0]  rdata;

  rr_arb2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept = (state == IDLE) && (|req_valid);

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  logic err;

  assign trap    = misaligned(lat);
  assign rsp_err = err;

  // error flag is captured with the access result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == ACCESS) begin
      err <= trap;
    end
  end
`else
  assign trap    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign mem_a     = lat.addr;
  assign mem_wd    = lat.wdata;
  assign mem_adtp  = lat.is_byte;
  assign rsp_rdata = rdata;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: one access cycle, response held until taken
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready[gsel]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake and write-enable outputs decoded from state
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE:    req_ready = grant;
      ACCESS:  mem_we = lat.we & ~trap;
      RESP:    rsp_valid[gsel] = 1'b1;
      default: ;
    endcase
  end

  // latch the winning request at accept time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat  <= '0;
      gsel <= 1'b0;
    end else if (accept) begin
      gsel        <= grant[1];
      lat.addr    <= req_addr[grant[1]];
      lat.wdata   <= req_wdata[grant[1]];
      lat.we      <= req_we[grant[1]];
      lat.is_byte <= req_byte[grant[1]];
    end
  end

  // capture read data and remember the winner at the access edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= '0;
      last_grant <= 1'b1;
    end else if (state == ACCESS) begin
      last_grant <= gsel;
      rdata      <= (lat.we | trap) ? '0 : mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a byte-array memory
// and a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       req_we;
  logic [1:0]       req_byte;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [31:0]      mem_a;
  logic [31:0]      mem_wd;
  logic             mem_we;
  logic             mem_adtp;
  logic [31:0]      mem_rd;

  logic [7:0] phys [0:255] = '{default: 8'h00};
  logic [7:0] refm [0:255] = '{default: 8'h00};

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int acc = 0;
  int mode = 0;
  int stall = 0;
  int ndone = 0;
  bit inflight = 0;
  logic last = 1'b1;
  logic cg = 1'b0;
  logic ctrap = 1'b0;
  logic [1:0] pres = 2'b00;
  mem_req_t cur;
  logic [31:0] exp_rd;
  logic exp_err;
  mem_req_t q0[$];
  mem_req_t q1[$];
  int glog[$];
  logic [31:0] rlog[$];

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_adtp  (mem_adtp),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (mem_adtp) begin
      mem_rd = {24'h0, phys[mem_a[7:0]]};
    end else begin
      mem_rd = {phys[mem_a[7:0] + 8'd3], phys[mem_a[7:0] + 8'd2],
                phys[mem_a[7:0] + 8'd1], phys[mem_a[7:0]]};
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      phys[mem_a[7:0]] <= mem_wd[7:0];
      if (!mem_adtp) begin
        phys[mem_a[7:0] + 8'd1] <= mem_wd[15:8];
        phys[mem_a[7:0] + 8'd2] <= mem_wd[23:16];
        phys[mem_a[7:0] + 8'd3] <= mem_wd[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic mem_req_t mk(input logic [31:0] a, input logic [31:0] d,
                                  input logic w, input logic b);
    mem_req_t r;
    r.addr = a;
    r.wdata = d;
    r.we = w;
    r.is_byte = b;
    return r;
  endfunction

  function automatic mem_req_t rnd_req();
    mem_req_t r;
    r.is_byte = 1'($urandom_range(0, 1));
    r.we = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    if (r.is_byte) r.addr = 32'h10000 + $urandom_range(0, 255);
    else r.addr = 32'h10000 + ($urandom_range(0, 63) << 2);
    return r;
  endfunction

  // one clock: drive at negedge, check 1ns later, advance model
  task automatic step();
    logic [1:0] er;
    logic [1:0] ev;
    logic [7:0] a;
    mem_req_t h0;
    mem_req_t h1;
    @(negedge clk);
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    if (!pres[0] && q0.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0))
      pres[0] = 1'b1;
    if (!pres[1] && q1.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0))
      pres[1] = 1'b1;
    req_valid = pres;
    req_addr[0] = h0.addr;
    req_wdata[0] = h0.wdata;
    req_we[0] = h0.we;
    req_byte[0] = h0.is_byte;
    req_addr[1] = h1.addr;
    req_wdata[1] = h1.wdata;
    req_we[1] = h1.we;
    req_byte[1] = h1.is_byte;
    if (mode == 1) rsp_ready = 2'($urandom_range(0, 3));
    else if (mode == 2) rsp_ready = {1'b1, stall == 0};
    else rsp_ready = 2'b11;
    #1;
    er = 2'b00;
    if (!inflight) begin
      if (pres == 2'b11) er = last ? 2'b01 : 2'b10;
      else er = pres;
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    if (inflight && cyc == acc + 1) begin
      chk("mem_a", mem_a, cur.addr);
      chk("mem_wd", mem_wd, cur.wdata);
      chk("mem_adtp", 32'(mem_adtp), 32'(cur.is_byte));
      chk("mem_we", 32'(mem_we), 32'(cur.we & ~ctrap));
    end else begin
      chk("mem_we_off", 32'(mem_we), 32'd0);
    end
    ev = (inflight && cyc >= acc + 2) ? (cg ? 2'b10 : 2'b01) : 2'b00;
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev != 2'b00) begin
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      if (rsp_ready[cg]) begin
        inflight = 0;
        ndone++;
        rlog.push_back(rsp_rdata);
      end else if (stall > 0) begin
        stall--;
      end
    end
    if (er != 2'b00) begin
      cg = er[1];
      cur = cg ? h1 : h0;
      if (cg) void'(q1.pop_front());
      else void'(q0.pop_front());
      pres[cg] = 1'b0;
      inflight = 1;
      acc = cyc;
      last = cg;
      glog.push_back(int'(cg));
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
      ctrap = !cur.is_byte && (cur.addr[1:0] != 2'b00);
`else
      ctrap = 1'b0;
`endif
      exp_err = ctrap;
      a = cur.addr[7:0];
      if (cur.we) begin
        exp_rd = 32'h0;
        if (!ctrap) begin
          refm[a] = cur.wdata[7:0];
          if (!cur.is_byte) begin
            refm[a + 8'd1] = cur.wdata[15:8];
            refm[a + 8'd2] = cur.wdata[23:16];
            refm[a + 8'd3] = cur.wdata[31:24];
          end
        end
      end else if (ctrap) begin
        exp_rd = 32'h0;
      end else if (cur.is_byte) begin
        exp_rd = {24'h0, refm[a]};
      end else begin
        exp_rd = {refm[a + 8'd3], refm[a + 8'd2], refm[a + 8'd1], refm[a]};
      end
    end
    cyc++;
  endtask

  task automatic run_phase(input int m);
    int budget;
    budget = 4000;
    mode = m;
    while (((q0.size() + q1.size()) != 0 || inflight) && budget > 0) begin
      step();
      budget--;
    end
    chk("phase_drain", 32'(q0.size() + q1.size() + int'(inflight)), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_mem_a"}, mem_a, 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_adtp"}, 32'(mem_adtp), 32'd0);
  endtask

  initial begin
    int n0;
    req_valid = '0;
    req_addr = '0;
    req_wdata = '0;
    req_we = '0;
    req_byte = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("idle");

    // write, then word and byte reads of the same word
    rlog.delete();
    q0.push_back(mk(32'h00010000, 32'hDEADBEEF, 1'b1, 1'b0));
    q0.push_back(mk(32'h00010000, 32'h0, 1'b0, 1'b0));
    q1.push_back(mk(32'h00010001, 32'h0, 1'b0, 1'b1));
    run_phase(0);
    chk("t1_count", 32'(rlog.size()), 32'd3);
    chk("t1_byte_rd", rlog[1], 32'h000000BE);
    chk("t1_word_rd", rlog[2], 32'hDEADBEEF);

    // leave last grant on requester 1, then full contention
    q1.push_back(mk(32'h00010004, 32'h0, 1'b0, 1'b0));
    run_phase(0);
    glog.delete();
    n0 = ndone;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(32'h10000 + ($urandom_range(0, 63) << 2), 32'h0, 1'b0, 1'b0));
      q1.push_back(mk(32'h10000 + ($urandom_range(0, 63) << 2), 32'h0, 1'b0, 1'b0));
    end
    run_phase(0);
    chk("cont_done", 32'(ndone - n0), 32'd8);
    chk("cont_grants", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("cont_order", 32'(glog[i]), 32'(i % 2));

    // response backpressure on requester 0
    stall = 5;
    q0.push_back(mk(32'h00010000, 32'h0, 1'b0, 1'b0));
    q1.push_back(mk(32'h00010008, 32'h0, 1'b0, 1'b0));
    q0.push_back(mk(32'h00010001, 32'h0, 1'b0, 1'b1));
    run_phase(2);
    chk("bp_stall_used", 32'(stall), 32'd0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) != 0) q0.push_back(rnd_req());
      else q1.push_back(rnd_req());
    end
    run_phase(1);

    // misaligned word write then aligned read back
    q0.push_back(mk(32'h00010002, 32'h11223344, 1'b1, 1'b0));
    q0.push_back(mk(32'h00010000, 32'h0, 1'b0, 1'b0));
    q0.push_back(mk(32'h00010004, 32'h0, 1'b0, 1'b0));
    run_phase(0);

    // reset while a write sits in its access cycle
    @(negedge clk);
    req_valid = 2'b01;
    req_addr[0] = 32'h00010010;
    req_wdata[0] = 32'hCAFEF00D;
    req_we = 2'b01;
    req_byte = 2'b00;
    rsp_ready = 2'b11;
    #1;
    chk("ra_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("ra_we_before", 32'(mem_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("ra");
    @(negedge clk);
    rst_n = 1'b1;
    chk("ra_nowrite",
        {phys[8'h13], phys[8'h12], phys[8'h11], phys[8'h10]},
        {refm[8'h13], refm[8'h12], refm[8'h11], refm[8'h10]});
    inflight = 0;
    last = 1'b1;
    pres = 2'b00;
    q0.push_back(mk(32'h00010010, 32'h0, 1'b0, 1'b0));
    q1.push_back(mk(32'h00010010, 32'h5A5A5A5A, 1'b1, 1'b0));
    q0.push_back(mk(32'h00010010, 32'h0, 1'b0, 1'b0));
    run_phase(0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d exp 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
